// File: rtl/mcyc_ctrl_exc.sv
// ============================================================================
// mcyc_ctrl_exc : multi-cycle MIPS control FSM with precise exceptions
// Rev 1.0
// ============================================================================
`default_nettype none

module mcyc_ctrl_exc #(
  parameter int MEM_TIMEOUT = 16,
  parameter bit OVF_TRAP    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst_in,
  input  logic        zero,
  input  logic        overflow,
  input  logic        MIO_ready,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch,
  output logic        CPU_MIO,
  output logic        ZeroExt,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [2:0]  ALU_operation,
  output logic [4:0]  state_out,
  output logic        exc_valid,
  output logic [1:0]  exc_code
);

  typedef enum logic [4:0] {
    S_IF = 5'd0, S_ID = 5'd1, S_MEM_ADDR = 5'd2, S_MEM_RD = 5'd3,
    S_LW_WB = 5'd4, S_MEM_WR = 5'd5, S_R_EXE = 5'd6, S_R_WB = 5'd7,
    S_BR_EXE = 5'd8, S_J = 5'd9, S_I_EXE = 5'd10, S_I_WB = 5'd11,
    S_LUI_WB = 5'd12, S_JR = 5'd13, S_JAL = 5'd14, S_EXC = 5'd15
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000,
                         ALU_OR  = 3'b001, ALU_XOR = 3'b011, ALU_NOR = 3'b100,
                         ALU_SLT = 3'b111, ALU_SRL = 3'b101;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010,
                         OP_JAL = 6'b000011, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010,
                         OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_XORI = 6'b001110,
                         OP_LUI = 6'b001111;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_JR = 6'b001000;

  localparam int              CW        = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   WAIT_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

  state_t        state, next_state;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    exc_cause;
  logic [5:0]    opcode, funct;
  logic [2:0]    r_op, i_op;
  logic          r_valid, i_zext;
  logic          bus_wait, timeout;
  logic          unused_ok;

  assign opcode    = Inst_in[31:26];
  assign funct     = Inst_in[5:0];
  assign state_out = state;
  // zero is consumed by the datapath through PCWriteCond/Branch
  assign unused_ok = ^{zero, Inst_in[25:6]};

  always_comb begin
    r_valid = 1'b1;
    r_op    = ALU_ADD;
    case (funct)
      6'b100000: r_op = ALU_ADD;
      6'b100010: r_op = ALU_SUB;
      6'b100100: r_op = ALU_AND;
      6'b100101: r_op = ALU_OR;
      6'b100110: r_op = ALU_XOR;
      6'b100111: r_op = ALU_NOR;
      6'b101010: r_op = ALU_SLT;
      6'b000010: r_op = ALU_SRL;
      default:   r_valid = 1'b0;
    endcase
    i_zext = 1'b0;
    i_op   = ALU_ADD;
    case (opcode)
      OP_ANDI: begin i_op = ALU_AND; i_zext = 1'b1; end
      OP_ORI:  begin i_op = ALU_OR;  i_zext = 1'b1; end
      OP_XORI: begin i_op = ALU_XOR; i_zext = 1'b1; end
      OP_SLTI: i_op = ALU_SLT;
      default: i_op = ALU_ADD;
    endcase
  end

  assign bus_wait = ((state == S_IF) || (state == S_MEM_RD) || (state == S_MEM_WR)) && !MIO_ready;
  assign timeout  = (MEM_TIMEOUT > 0) && bus_wait && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IF;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    exc_cause     = 2'b00;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IorD          = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    Branch        = 1'b0;
    CPU_MIO       = 1'b0;
    ZeroExt       = 1'b0;
    RegDst        = 2'b00;
    MemtoReg      = 2'b00;
    ALUSrcB       = 2'b00;
    PCSource      = 2'b00;
    ALU_operation = ALU_ADD;
    exc_valid     = 1'b0;
    case (state)
      S_IF: begin
        MemRead = 1'b1; CPU_MIO = 1'b1; ALUSrcB = 2'b01;
        PCWrite = MIO_ready; IRWrite = MIO_ready;
        if (MIO_ready)    next_state = S_ID;
        else if (timeout) begin next_state = S_EXC; exc_cause = 2'b11; end
      end
      S_ID: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_R: begin
            if (funct == FN_JR) next_state = S_JR;
            else if (r_valid)   next_state = S_R_EXE;
            else begin next_state = S_EXC; exc_cause = 2'b01; end
          end
          OP_LW, OP_SW:                           next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                         next_state = S_BR_EXE;
          OP_J:                                   next_state = S_J;
          OP_JAL:                                 next_state = S_JAL;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: next_state = S_I_EXE;
          OP_LUI:                                 next_state = S_LUI_WB;
          default: begin next_state = S_EXC; exc_cause = 2'b01; end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10;
        next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        IorD = 1'b1; MemRead = 1'b1; CPU_MIO = 1'b1;
        if (MIO_ready)    next_state = S_LW_WB;
        else if (timeout) begin next_state = S_EXC; exc_cause = 2'b11; end
      end
      S_LW_WB: begin
        RegWrite = 1'b1; MemtoReg = 2'b01;
        next_state = S_IF;
      end
      S_MEM_WR: begin
        IorD = 1'b1; MemWrite = 1'b1; CPU_MIO = 1'b1;
        if (MIO_ready)    next_state = S_IF;
        else if (timeout) begin next_state = S_EXC; exc_cause = 2'b11; end
      end
      S_R_EXE: begin
        ALUSrcA = 1'b1; ALU_operation = r_op;
        if (OVF_TRAP && (funct == FN_ADD) && overflow) begin
          next_state = S_EXC; exc_cause = 2'b10;
        end else next_state = S_R_WB;
      end
      S_R_WB: begin
        RegWrite = 1'b1; RegDst = 2'b01; ALU_operation = r_op;
        next_state = S_IF;
      end
      S_BR_EXE: begin
        ALUSrcA = 1'b1; ALU_operation = ALU_SUB; PCWriteCond = 1'b1;
        PCSource = 2'b01; Branch = (opcode == OP_BEQ);
        next_state = S_IF;
      end
      S_J: begin
        PCWrite = 1'b1; PCSource = 2'b10;
        next_state = S_IF;
      end
      S_I_EXE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALU_operation = i_op; ZeroExt = i_zext;
        if (OVF_TRAP && (opcode == OP_ADDI) && overflow) begin
          next_state = S_EXC; exc_cause = 2'b10;
        end else next_state = S_I_WB;
      end
      S_I_WB: begin
        RegWrite = 1'b1; ALU_operation = i_op; ZeroExt = i_zext;
        next_state = S_IF;
      end
      S_LUI_WB: begin
        RegWrite = 1'b1; MemtoReg = 2'b10;
        next_state = S_IF;
      end
      S_JR: begin
        PCWrite = 1'b1; PCSource = 2'b11;
        next_state = S_IF;
      end
      S_JAL: begin
        PCWrite = 1'b1; PCSource = 2'b10; RegWrite = 1'b1;
        RegDst = 2'b10; MemtoReg = 2'b11;
        next_state = S_IF;
      end
      S_EXC: begin
        PCWrite = 1'b1; exc_valid = 1'b1;
        next_state = S_IF;
      end
      default: next_state = S_IF;
    endcase
  end

  // Wait counter restarts on any handshake or state change, so each memory
  // access gets the full timeout window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      exc_code <= 2'b00;
    end else begin
      if ((next_state == S_EXC) && (state != S_EXC)) exc_code <= exc_cause;
      if (bus_wait && (next_state == state) && (MEM_TIMEOUT > 0)) wait_cnt <= wait_cnt + 1'b1;
      else                                                       wait_cnt <= '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mcyc_ctrl_exc.sv
// ============================================================================
// tb_mcyc_ctrl_exc : directed self-checking bench for mcyc_ctrl_exc
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mcyc_ctrl_exc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Inst_in = 32'd0;
  logic        zero = 1'b0, overflow = 1'b0, MIO_ready = 1'b0;

  logic MemRead, MemWrite, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond;
  logic Branch, CPU_MIO, ZeroExt, exc_valid;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource, exc_code;
  logic [2:0] ALU_operation;
  logic [4:0] state_out;

  logic b_MemRead, b_MemWrite, b_IorD, b_IRWrite, b_RegWrite, b_ALUSrcA, b_PCWrite;
  logic b_PCWriteCond, b_Branch, b_CPU_MIO, b_ZeroExt, b_exc_valid;
  logic [1:0] b_RegDst, b_MemtoReg, b_ALUSrcB, b_PCSource, b_exc_code;
  logic [2:0] b_ALU_operation;
  logic [4:0] b_state_out;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] I_LW  = {6'b100011, 26'd0};
  localparam logic [31:0] I_SW  = {6'b101011, 26'd0};
  localparam logic [31:0] I_BNE = {6'b000101, 26'd0};
  localparam logic [31:0] I_ADD = {6'b000000, 20'd0, 6'b100000};
  localparam logic [31:0] I_JR  = {6'b000000, 20'd0, 6'b001000};
  localparam logic [31:0] I_ORI = {6'b001101, 26'd0};
  localparam logic [31:0] I_JAL = {6'b000011, 26'd0};
  localparam logic [31:0] I_LUI = {6'b001111, 26'd0};
  localparam logic [31:0] I_ILL = {6'b111111, 26'd0};

  mcyc_ctrl_exc #(.MEM_TIMEOUT(4), .OVF_TRAP(1'b1)) dut (
    .clk(clk), .reset(reset), .Inst_in(Inst_in), .zero(zero), .overflow(overflow),
    .MIO_ready(MIO_ready), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .Branch(Branch), .CPU_MIO(CPU_MIO), .ZeroExt(ZeroExt),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALU_operation(ALU_operation), .state_out(state_out), .exc_valid(exc_valid),
    .exc_code(exc_code)
  );

  mcyc_ctrl_exc #(.MEM_TIMEOUT(16), .OVF_TRAP(1'b0)) dut_novf (
    .clk(clk), .reset(reset), .Inst_in(Inst_in), .zero(zero), .overflow(overflow),
    .MIO_ready(MIO_ready), .MemRead(b_MemRead), .MemWrite(b_MemWrite), .IorD(b_IorD),
    .IRWrite(b_IRWrite), .RegWrite(b_RegWrite), .ALUSrcA(b_ALUSrcA), .PCWrite(b_PCWrite),
    .PCWriteCond(b_PCWriteCond), .Branch(b_Branch), .CPU_MIO(b_CPU_MIO), .ZeroExt(b_ZeroExt),
    .RegDst(b_RegDst), .MemtoReg(b_MemtoReg), .ALUSrcB(b_ALUSrcB), .PCSource(b_PCSource),
    .ALU_operation(b_ALU_operation), .state_out(b_state_out), .exc_valid(b_exc_valid),
    .exc_code(b_exc_code)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    do_reset();
    check_eq("rst_state", 32'(state_out), 32'd0);
    check_eq("rst_exc_code", 32'(exc_code), 32'd0);
    check_eq("rst_memread", 32'(MemRead), 32'd1);
    check_eq("rst_cpu_mio", 32'(CPU_MIO), 32'd1);
    check_eq("rst_alusrcb", 32'(ALUSrcB), 32'd1);
    check_eq("rst_pcwrite_nordy", 32'(PCWrite), 32'd0);
    check_eq("rst_irwrite_nordy", 32'(IRWrite), 32'd0);
    check_eq("rst_regwrite", 32'(RegWrite), 32'd0);
    MIO_ready = 1'b1;
    #1;
    check_eq("if_pcwrite_rdy", 32'(PCWrite), 32'd1);
    check_eq("if_irwrite_rdy", 32'(IRWrite), 32'd1);

    // LW with one wait state in MEM_RD
    Inst_in = I_LW;
    step(); check_eq("lw_id", 32'(state_out), 32'd1);
    check_eq("id_pcwrite", 32'(PCWrite), 32'd0);
    check_eq("id_irwrite", 32'(IRWrite), 32'd0);
    check_eq("id_alusrcb", 32'(ALUSrcB), 32'd3);
    step(); check_eq("lw_addr", 32'(state_out), 32'd2);
    check_eq("addr_alusrca", 32'(ALUSrcA), 32'd1);
    check_eq("addr_alusrcb", 32'(ALUSrcB), 32'd2);
    MIO_ready = 1'b0;
    step(); check_eq("lw_rd", 32'(state_out), 32'd3);
    check_eq("lw_rd_iord", 32'(IorD), 32'd1);
    check_eq("lw_rd_regwrite", 32'(RegWrite), 32'd0);
    step(); check_eq("lw_rd_wait", 32'(state_out), 32'd3);
    MIO_ready = 1'b1;
    step(); check_eq("lw_wb", 32'(state_out), 32'd4);
    check_eq("lw_wb_regwrite", 32'(RegWrite), 32'd1);
    check_eq("lw_wb_memtoreg", 32'(MemtoReg), 32'd1);
    step(); check_eq("lw_done", 32'(state_out), 32'd0);

    // BNE, not taken zero flag
    Inst_in = I_BNE;
    step(); step();
    check_eq("bne_state", 32'(state_out), 32'd8);
    check_eq("bne_branch", 32'(Branch), 32'd0);
    check_eq("bne_pcwcond", 32'(PCWriteCond), 32'd1);
    check_eq("bne_pcsource", 32'(PCSource), 32'd1);
    check_eq("bne_aluop", 32'(ALU_operation), 32'h6);
    step(); check_eq("bne_done", 32'(state_out), 32'd0);

    // ADD overflow: trapping and non-trapping instances
    Inst_in = I_ADD;
    step(); step();
    check_eq("add_exe", 32'(state_out), 32'd6);
    overflow = 1'b1;
    #1;
    check_eq("add_aluop", 32'(ALU_operation), 32'h2);
    check_eq("add_exe_regwrite", 32'(RegWrite), 32'd0);
    step();
    check_eq("ovf_exc_state", 32'(state_out), 32'd15);
    check_eq("ovf_exc_valid", 32'(exc_valid), 32'd1);
    check_eq("ovf_exc_pcwrite", 32'(PCWrite), 32'd1);
    check_eq("ovf_exc_regwrite", 32'(RegWrite), 32'd0);
    check_eq("novf_wb_state", 32'(b_state_out), 32'd7);
    check_eq("novf_wb_regwrite", 32'(b_RegWrite), 32'd1);
    overflow = 1'b0;
    step();
    check_eq("ovf_back_if", 32'(state_out), 32'd0);
    check_eq("ovf_exc_code", 32'(exc_code), 32'd2);
    check_eq("novf_back_if", 32'(b_state_out), 32'd0);
    check_eq("novf_exc_code", 32'(b_exc_code), 32'd0);

    // ORI: zero-extended OR, op held into write-back
    Inst_in = I_ORI;
    step(); step();
    check_eq("ori_exe", 32'(state_out), 32'd10);
    check_eq("ori_zext", 32'(ZeroExt), 32'd1);
    check_eq("ori_aluop", 32'(ALU_operation), 32'h1);
    step();
    check_eq("ori_wb", 32'(state_out), 32'd11);
    check_eq("ori_wb_regwrite", 32'(RegWrite), 32'd1);
    check_eq("ori_wb_zext", 32'(ZeroExt), 32'd1);
    check_eq("ori_wb_aluop", 32'(ALU_operation), 32'h1);
    step(); check_eq("ori_done", 32'(state_out), 32'd0);

    // JAL
    Inst_in = I_JAL;
    step(); step();
    check_eq("jal_state", 32'(state_out), 32'd14);
    check_eq("jal_regdst", 32'(RegDst), 32'd2);
    check_eq("jal_memtoreg", 32'(MemtoReg), 32'd3);
    check_eq("jal_pcsource", 32'(PCSource), 32'd2);
    check_eq("jal_regwrite", 32'(RegWrite), 32'd1);
    step(); check_eq("jal_done", 32'(state_out), 32'd0);

    // JR
    Inst_in = I_JR;
    step(); step();
    check_eq("jr_state", 32'(state_out), 32'd13);
    check_eq("jr_pcsource", 32'(PCSource), 32'd3);
    check_eq("jr_pcwrite", 32'(PCWrite), 32'd1);
    step(); check_eq("jr_done", 32'(state_out), 32'd0);

    // LUI
    Inst_in = I_LUI;
    step(); step();
    check_eq("lui_state", 32'(state_out), 32'd12);
    check_eq("lui_memtoreg", 32'(MemtoReg), 32'd2);
    check_eq("lui_regwrite", 32'(RegWrite), 32'd1);
    step(); check_eq("lui_done", 32'(state_out), 32'd0);

    // Illegal opcode
    Inst_in = I_ILL;
    step(); check_eq("ill_id", 32'(state_out), 32'd1);
    step(); check_eq("ill_exc", 32'(state_out), 32'd15);
    step();
    check_eq("ill_back_if", 32'(state_out), 32'd0);
    check_eq("ill_exc_code", 32'(exc_code), 32'd1);

    // SW bus timeout (MEM_TIMEOUT=4)
    do_reset();
    MIO_ready = 1'b1;
    Inst_in = I_SW;
    step(); step();
    check_eq("sw_addr", 32'(state_out), 32'd2);
    MIO_ready = 1'b0;
    step(); check_eq("sw_wait1", 32'(state_out), 32'd5);
    check_eq("sw_memwrite", 32'(MemWrite), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      step(); check_eq($sformatf("sw_wait%0d", i), 32'(state_out), 32'd5);
    end
    step();
    check_eq("to_exc_state", 32'(state_out), 32'd15);
    check_eq("to_exc_valid", 32'(exc_valid), 32'd1);
    MIO_ready = 1'b1;
    step();
    check_eq("to_back_if", 32'(state_out), 32'd0);
    check_eq("to_exc_code", 32'(exc_code), 32'd3);

    // SW with ready arriving on the final allowed cycle: no exception
    step(); step();
    MIO_ready = 1'b0;
    step(); step(); step(); step();
    check_eq("late_wait4", 32'(state_out), 32'd5);
    MIO_ready = 1'b1;
    step();
    check_eq("late_rdy_if", 32'(state_out), 32'd0);
    check_eq("late_exc_valid", 32'(exc_valid), 32'd0);
    check_eq("exc_code_held", 32'(exc_code), 32'd3);

    // Asynchronous reset while in MEM_RD
    Inst_in = I_LW;
    step(); step();
    MIO_ready = 1'b0;
    step();
    check_eq("pre_rst_rd", 32'(state_out), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_rst_state", 32'(state_out), 32'd0);
    check_eq("async_rst_exc_code", 32'(exc_code), 32'd0);
    check_eq("async_rst_memwrite", 32'(MemWrite), 32'd0);
    reset = 1'b0;
    step();
    check_eq("post_rst_if_stall", 32'(state_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mcyc_ctrl_exc.md
# mcyc_ctrl_exc

Multi-cycle MIPS control unit, next generation of the CPU's control FSM. Sequences fetch/decode/execute/memory/write-back for the full supported ISA (including BNE, LUI, JAL, JR), stalls on `MIO_ready` with a parametrised bus timeout, and raises precise exceptions for illegal opcodes, arithmetic overflow and bus timeout. It sits between the instruction register and the multi-cycle datapath.

## Interface

- `MEM_TIMEOUT`, default 16: number of consecutive not-ready cycles in a memory state before a bus-timeout exception. 0 disables the timeout.
- `OVF_TRAP`, default 1: 1 makes ADD/ADDI overflow trap; 0 ignores overflow.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `Inst_in` in 32: IR contents, stable from ID until the next IF.
- `zero`, `overflow` in 1: ALU flags, combinational from the current ALU inputs.
- `MIO_ready` in 1: memory/IO handshake.
- `MemRead`, `MemWrite`, `IorD`, `IRWrite`, `RegWrite`, `ALUSrcA`, `PCWrite`, `PCWriteCond`, `Branch`, `CPU_MIO`, `ZeroExt` out 1: datapath controls.
- `RegDst`, `MemtoReg`, `ALUSrcB`, `PCSource` out 2: mux selects.
- `ALU_operation` out 3: ADD=010, SUB=110, AND=000, OR=001, XOR=011, NOR=100, SLT=111, SRL=101.
- `state_out` out 5: current state encoding.
- `exc_valid` out 1: high during the EXC state; the datapath loads the exception vector into PC.
- `exc_code` out 2: cause of the last exception. 01 = illegal, 10 = overflow, 11 = bus timeout.

## Operation

- Outputs are decoded combinationally from the registered state and `Inst_in`. Only IF write-enables also depend on `MIO_ready`. Any signal not listed for a state is 0, and `ALU_operation` is ADD.
- Mux encodings:
  - `RegDst`: 00 rt, 01 rd, 10 $31.
  - `MemtoReg`: 00 ALUOut, 01 MDR, 10 {imm,16'h0}, 11 PC.
  - `ALUSrcB`: 00 B, 01 4, 10 imm-ext, 11 imm-ext<<2.
  - `PCSource`: 00 ALU, 01 ALUOut, 10 jump target, 11 register A.
- States (5-bit) and their outputs:
  - IF=0: MemRead, CPU_MIO, ALUSrcB=01; PCWrite=IRWrite=`MIO_ready`. Go to ID on ready.
  - ID=1: ALUSrcB=11, which precomputes the branch target. Dispatch on opcode; an unknown opcode or funct goes to EXC with code 01.
  - MEM_ADDR=2: ALUSrcA=1, ALUSrcB=10. LW goes to MEM_RD, SW goes to MEM_WR.
  - MEM_RD=3: IorD, MemRead, CPU_MIO. Go to LW_WB on ready.
  - LW_WB=4: RegWrite, MemtoReg=01, RegDst=00.
  - MEM_WR=5: IorD, MemWrite, CPU_MIO. Go to IF on ready.
  - R_EXE=6: ALUSrcA=1, ALUSrcB=00, op from funct. funct 100000/100010/100100/100101/100110/100111/101010/000010 map to ADD/SUB/AND/OR/XOR/NOR/SLT/SRL.
  - R_WB=7: RegWrite, RegDst=01, op held.
  - BR_EXE=8: ALUSrcA=1, ALUSrcB=00, SUB, PCWriteCond, PCSource=01. Branch=1 for BEQ (000100) and 0 for BNE (000101).
  - J=9: PCWrite, PCSource=10.
  - I_EXE=10: ALUSrcA=1, ALUSrcB=10. ADDI/ANDI/ORI/XORI/SLTI map to ADD/AND/OR/XOR/SLT. ZeroExt=1 for ANDI/ORI/XORI.
  - I_WB=11: RegWrite, RegDst=00, ZeroExt and op held.
  - LUI_WB=12: RegWrite, MemtoReg=10.
  - JR=13 (funct 001000): PCWrite, PCSource=11.
  - JAL=14: PCWrite, PCSource=10, RegWrite, RegDst=10, MemtoReg=11.
  - EXC=15: PCWrite, exc_valid. Go to IF.
- Every WB, BR_EXE, J, JR and JAL state returns to IF.
- Overflow trap: when `OVF_TRAP`=1, in R_EXE for ADD or I_EXE for ADDI, `overflow`=1 sends the FSM to EXC with code 10, skipping WB. No register is written.
- Bus timeout: a wait counter ($clog2(MEM_TIMEOUT+1) bits) increments each cycle `MIO_ready`=0 in IF/MEM_RD/MEM_WR.
  - The counter clears on `MIO_ready`=1 and on any state change.
  - When the counter reaches MEM_TIMEOUT-1 while still not ready, the next state is EXC with code 11.
  - `MIO_ready` arriving on that same cycle wins: normal transition, no exception.
- `exc_code` is registered. It updates only on entry to EXC and holds until the next exception.

## Timing

- Reset values: state=IF. Outputs are the IF decode: MemRead=1, CPU_MIO=1, ALUSrcB=01, PCWrite=IRWrite=`MIO_ready`, everything else 0. `exc_code`=00, wait counter=0.
- Reset mid-instruction aborts immediately, asynchronously, with no pending writes.
- Cycles with zero wait states:
  - LW: 5.
  - SW, R-type, I-type: 4.
  - LUI, BEQ/BNE, J, JAL, JR: 3.
  - Exception: ID/EXE + 1 EXC cycle.
- Each not-ready cycle adds one cycle. IR and PC do not change while IF stalls.

## Test plan

- Reset, then IF with `MIO_ready`=1 -> `state_out` 0→1; PCWrite/IRWrite high for exactly one cycle; exc_code=00.
- LW (opcode 100011), one wait cycle in MEM_RD -> states 0,1,2,3,3,4,0; RegWrite with MemtoReg=01 only in state 4.
- BNE (000101) with zero=0 -> state 8 with Branch=0, PCWriteCond=1, PCSource=01, ALU_operation=110.
- ADD, `overflow`=1 in R_EXE, OVF_TRAP=1 -> state 6→15→0, exc_code=10, RegWrite never asserted. With OVF_TRAP=0 -> 6→7 with RegWrite.
- SW with MEM_TIMEOUT=4 and `MIO_ready` held low -> 4 cycles in state 5, then 15 with exc_code=11. Ready on the 4th cycle -> state 0 with no exception.
- Opcode 111111 -> 1→15→0, exc_code=01. Assert reset during state 3 -> state_out=0 immediately.
